spi_cache_loader: RTL and testbench

//  Serial loader/readback controller for the instruction and data caches. Decodes SPI frames from the

---
 rtl/tiny_proc_pkg.sv | 22 ++
 rtl/sipo_frame.sv | 52 +++++
 rtl/spi_cache_loader.sv | 181 ++++++++++++++++++
 tb/tb_spi_cache_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_proc_pkg.sv
// Shared widths, command encoding, loader FSM state codes and error codes
// for the SPI cache loader.
package tiny_proc_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 4;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_HDR   = 3'd1;
   localparam logic [2:0] ST_WDATA = 3'd2;
   localparam logic [2:0] ST_RTURN = 3'd3;
   localparam logic [2:0] ST_RDATA = 3'd4;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ABORT   = 2'd1;
   localparam logic [1:0] ERR_OVERRUN = 2'd2;
   localparam logic [1:0] ERR_BADSEL  = 2'd3;

endpackage

// File: rtl/sipo_frame.sv
// Serial-in shifter for the address/data part of a frame, with a down-counter
// that flags the last header bit and the last data bit as they are sampled.
module sipo_frame #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     shift_en,
   input  logic                     bit_in,
   output logic [ADDR_W-1:0]        rd_addr,
   output logic [ADDR_W+DATA_W-1:0] frame_word,
   output logic                     hdr_done,
   output logic                     frame_done
);
   localparam int SH_W  = ADDR_W + DATA_W;
   localparam int CNT_W = $clog2(SH_W);

   logic [SH_W-1:0]  sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The command bit is sampled at frame start and kept by the caller, so the
   // shifter starts empty and counts the remaining address+data bits.
   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (start) begin
         sreg_d = '0;
         cnt_d  = CNT_W'(SH_W - 1);
      end else if (shift_en) begin
         sreg_d = {sreg_q[SH_W-2:0], bit_in};
         cnt_d  = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg_q <= '0;
         cnt_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
      end
   end

   assign rd_addr    = sreg_q[ADDR_W-1:0];
   assign frame_word = sreg_d;
   assign hdr_done   = shift_en && (cnt_q == CNT_W'(DATA_W));
   assign frame_done = shift_en && (cnt_q == '0);

endmodule

// File: rtl/spi_cache_loader.sv
// SPI frame decoder that loads and reads back the instruction/data caches
// while the core is idle, parking one write while the core runs.
//
// state    | meaning
// IDLE     | no frame; a single cs_n low starts one and samples the command bit
// HDR      | shifting address bits
// WDATA    | shifting write data; last bit hands the word to the pending slot
// RTURN    | turnaround: read the cache into the readback shifter
// RDATA    | shifting readback data out on miso
module spi_cache_loader
   import tiny_proc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              csi_n,
   input  logic              csd_n,
   input  logic              mosi,
   output logic              miso,
   input  logic              core_busy,
   output logic              mem_req,
   output logic              mem_sel,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              err_clr,
   output logic [1:0]        err_code,
   output logic              busy
);
   localparam int RCNT_W = $clog2(DATA_W);

   logic [2:0]              state_q, state_d;
   logic                    tgt_q, tgt_d;
   logic                    cmd_q, cmd_d;
   logic                    blk_q, blk_d;
   logic                    pend_q, pend_d;
   logic                    pend_sel_q, pend_sel_d;
   logic [ADDR_W-1:0]       pend_addr_q, pend_addr_d;
   logic [DATA_W-1:0]       pend_data_q, pend_data_d;
   logic [DATA_W-1:0]       rsh_q, rsh_d;
   logic [RCNT_W-1:0]       rcnt_q, rcnt_d;
   logic [1:0]              err_q, err_d;
   logic [ADDR_W-1:0]       addr_hold_q, addr_hold_d;
   logic [DATA_W-1:0]       data_hold_q, data_hold_d;

   logic                    start, shift_en, abort, commit, read_req;
   logic                    hdr_done, frame_done;
   logic [ADDR_W-1:0]       rd_addr;
   logic [ADDR_W+DATA_W-1:0] frame_word;

   sipo_frame #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_sipo (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .shift_en   (shift_en),
      .bit_in     (mosi),
      .rd_addr    (rd_addr),
      .frame_word (frame_word),
      .hdr_done   (hdr_done),
      .frame_done (frame_done)
   );

   // The target is fixed at frame start; only its own cs_n can abort the frame.
   assign abort    = (state_q != ST_IDLE) && (tgt_q ? csd_n : csi_n);
   assign start    = (state_q == ST_IDLE) && !blk_q && (csi_n != csd_n);
   assign shift_en = !abort && ((state_q == ST_HDR) || (state_q == ST_WDATA));
   assign commit   = pend_q && !core_busy && !rst;
   assign read_req = (state_q == ST_RTURN) && !abort && !core_busy && !pend_q && !rst;

   assign mem_req   = commit || read_req;
   assign mem_wen   = commit;
   assign mem_sel   = commit ? pend_sel_q : tgt_q;
   assign mem_addr  = commit ? pend_addr_q : (read_req ? rd_addr : addr_hold_q);
   assign mem_wdata = commit ? pend_data_q : data_hold_q;
   assign miso      = (state_q == ST_RDATA) && rsh_q[DATA_W-1];
   assign busy      = (state_q != ST_IDLE) || pend_q;
   assign err_code  = err_q;

   always_comb begin
      state_d     = state_q;
      tgt_d       = tgt_q;
      cmd_d       = cmd_q;
      blk_d       = blk_q;
      pend_d      = pend_q && !commit;
      pend_sel_d  = pend_sel_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      rsh_d       = rsh_q;
      rcnt_d      = rcnt_q;
      err_d       = err_clr ? ERR_NONE : err_q;
      addr_hold_d = mem_addr;
      data_hold_d = mem_wdata;
      case (state_q)
         ST_IDLE: begin
            if (blk_q) begin
               if (csi_n && csd_n) blk_d = 1'b0;
            end else if (!csi_n && !csd_n) begin
               err_d = ERR_BADSEL;
               blk_d = 1'b1;
            end else if (start) begin
               tgt_d   = csi_n;
               cmd_d   = mosi;
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            if (hdr_done) state_d = (cmd_q == CMD_WRITE) ? ST_WDATA : ST_RTURN;
         end
         ST_WDATA: begin
            if (frame_done) begin
               state_d = ST_IDLE;
               // A still-occupied slot keeps the older write; the new one is lost.
               if (pend_q && !commit) begin
                  err_d = ERR_OVERRUN;
               end else begin
                  pend_d      = 1'b1;
                  pend_sel_d  = tgt_q;
                  pend_addr_d = frame_word[DATA_W +: ADDR_W];
                  pend_data_d = frame_word[DATA_W-1:0];
               end
            end
         end
         ST_RTURN: begin
            state_d = ST_RDATA;
            rcnt_d  = RCNT_W'(DATA_W - 1);
            if (read_req) begin
               rsh_d = mem_rdata;
            end else begin
               rsh_d = '0;
               err_d = ERR_OVERRUN;
            end
         end
         ST_RDATA: begin
            rsh_d  = {rsh_q[DATA_W-2:0], 1'b0};
            rcnt_d = rcnt_q - 1'b1;
            if (rcnt_q == '0) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort) begin
         state_d = ST_IDLE;
         err_d   = ERR_ABORT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tgt_q       <= 1'b0;
         cmd_q       <= 1'b0;
         blk_q       <= 1'b0;
         pend_q      <= 1'b0;
         pend_sel_q  <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         rsh_q       <= '0;
         rcnt_q      <= '0;
         err_q       <= ERR_NONE;
         addr_hold_q <= '0;
         data_hold_q <= '0;
      end else begin
         state_q     <= state_d;
         tgt_q       <= tgt_d;
         cmd_q       <= cmd_d;
         blk_q       <= blk_d;
         pend_q      <= pend_d;
         pend_sel_q  <= pend_sel_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         rsh_q       <= rsh_d;
         rcnt_q      <= rcnt_d;
         err_q       <= err_d;
         addr_hold_q <= addr_hold_d;
         data_hold_q <= data_hold_d;
      end
   end

endmodule

// File: tb/tb_spi_cache_loader.sv
// Directed bench for spi_cache_loader: a frame-position model predicts every
// output each cycle, and literal checks pin the headline scenarios.
module tb_spi_cache_loader;
   localparam int DW = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1, csi_n = 1'b1, csd_n = 1'b1, mosi = 1'b0, core_busy = 1'b0, err_clr = 1'b0;
   logic miso, mem_req, mem_sel, mem_wen, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [1:0]    err_code;
   logic [DW-1:0] imem [16];
   logic [DW-1:0] dmem [16];

   always #5 clk = ~clk;
   assign mem_rdata = mem_sel ? dmem[mem_addr] : imem[mem_addr];

   spi_cache_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .csi_n(csi_n), .csd_n(csd_n), .mosi(mosi), .miso(miso),
      .core_busy(core_busy), .mem_req(mem_req), .mem_sel(mem_sel), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .err_clr(err_clr), .err_code(err_code), .busy(busy)
   );

   int errors = 0;
   int checks = 0;

   logic exp_valid = 1'b0;
   logic exp_req, exp_wen, exp_miso, exp_busy, exp_sel;
   logic [1:0] exp_err;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata;

   // Model: m_pos is the cycle index inside the current frame (0 = no frame).
   int m_pos = 0, n_pos = 0;
   logic m_tgt = 0, n_tgt = 0, m_cmd = 0, n_cmd = 0, m_blk = 0, n_blk = 0;
   logic [AW+DW-1:0] m_word = '0, n_word = '0;
   logic [DW-1:0] m_rbuf = '0, n_rbuf = '0;
   logic m_pv = 0, n_pv = 0, m_ps = 0, n_ps = 0;
   logic [AW-1:0] m_pa = '0, n_pa = '0;
   logic [DW-1:0] m_pd = '0, n_pd = '0;
   logic [1:0] m_err = '0, n_err = '0;

   logic [AW+DW:0] commits [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_valid) begin
         chk("mem_req", mem_req, exp_req);
         chk("mem_wen", mem_wen, exp_wen);
         chk("miso", miso, exp_miso);
         chk("busy", busy, exp_busy);
         chk("err_code", err_code, exp_err);
         if (exp_req) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_sel", mem_sel, exp_sel);
            if (exp_wen) chk("mem_wdata", mem_wdata, exp_wdata);
         end
         if (mem_wen) commits.push_back({mem_sel, mem_addr, mem_wdata});
      end
   end

   task model_adv();
      m_pos = n_pos; m_tgt = n_tgt; m_cmd = n_cmd; m_blk = n_blk; m_word = n_word;
      m_rbuf = n_rbuf; m_pv = n_pv; m_ps = n_ps; m_pa = n_pa; m_pd = n_pd; m_err = n_err;
   endtask

   task model_eval(input logic r, input logic ci, input logic cd, input logic mo,
                   input logic cb, input logic clr);
      logic wr_now;
      logic selcs;
      n_pos = m_pos; n_tgt = m_tgt; n_cmd = m_cmd; n_blk = m_blk; n_word = m_word;
      n_rbuf = m_rbuf; n_pv = m_pv; n_ps = m_ps; n_pa = m_pa; n_pd = m_pd;
      exp_req = 0; exp_wen = 0; exp_miso = 0; exp_sel = 0; exp_addr = '0; exp_wdata = '0;
      exp_busy  = (m_pos > 0) || m_pv;
      exp_err   = m_err;
      exp_valid = !r;
      n_err     = clr ? 2'd0 : m_err;
      wr_now    = m_pv && !cb;
      if (wr_now) begin
         exp_req = 1; exp_wen = 1; exp_sel = m_ps; exp_addr = m_pa; exp_wdata = m_pd;
         n_pv = 0;
      end
      if (m_pos == 0) begin
         if (m_blk) begin
            if (ci && cd) n_blk = 0;
         end else if (!ci && !cd) begin
            n_err = 2'd3; n_blk = 1;
         end else if (ci != cd) begin
            n_tgt = ci; n_cmd = mo; n_word = '0; n_pos = 1;
         end
      end else begin
         selcs = m_tgt ? cd : ci;
         if (selcs) begin
            n_err = 2'd1; n_pos = 0;
         end else if (m_cmd) begin
            n_word = {m_word[AW+DW-2:0], mo};
            if (m_pos == AW + DW) begin
               n_pos = 0;
               if (m_pv && !wr_now) n_err = 2'd2;
               else begin
                  n_pv = 1; n_ps = m_tgt; n_pa = n_word[DW +: AW]; n_pd = n_word[DW-1:0];
               end
            end else n_pos = m_pos + 1;
         end else if (m_pos <= AW) begin
            n_word = {m_word[AW+DW-2:0], mo};
            n_pos  = m_pos + 1;
         end else if (m_pos == AW + 1) begin
            if (cb || m_pv) begin
               n_rbuf = '0; n_err = 2'd2;
            end else begin
               exp_req = 1; exp_sel = m_tgt; exp_addr = m_word[AW-1:0];
               n_rbuf = m_tgt ? dmem[m_word[AW-1:0]] : imem[m_word[AW-1:0]];
            end
            n_pos = m_pos + 1;
         end else begin
            exp_miso = m_rbuf[DW-1-(m_pos-AW-2)];
            n_pos = (m_pos == AW + 1 + DW) ? 0 : m_pos + 1;
         end
      end
      if (r) begin
         n_pos = 0; n_tgt = 0; n_cmd = 0; n_blk = 0; n_word = '0; n_rbuf = '0;
         n_pv = 0; n_ps = 0; n_pa = '0; n_pd = '0; n_err = '0;
      end
   endtask

   task step(input logic r, input logic ci, input logic cd, input logic mo,
             input logic cb, input logic clr);
      @(posedge clk);
      #1;
      model_adv();
      rst = r; csi_n = ci; csd_n = cd; mosi = mo; core_busy = cb; err_clr = clr;
      model_eval(r, ci, cd, mo, cb, clr);
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic cb);
      for (int i = 0; i < n; i++) step(0, 1, 1, 0, cb, 0);
   endtask

   task automatic send_write(input logic d, input logic [AW-1:0] a, input logic [DW-1:0] v,
                             input logic cb);
      logic [AW+DW:0] f;
      f = {1'b1, a, v};
      for (int i = AW + DW; i >= 0; i--) step(0, d, !d, f[i], cb, 0);
   endtask

   task automatic send_read(input logic d, input logic [AW-1:0] a, input logic cb,
                            output logic [DW-1:0] got);
      logic [AW:0] f;
      f = {1'b0, a};
      got = '0;
      for (int i = AW; i >= 0; i--) step(0, d, !d, f[i], cb, 0);
      step(0, d, !d, 1'b1, cb, 0);
      for (int i = 0; i < DW; i++) begin
         step(0, d, !d, 1'b1, cb, 0);
         got = {got[DW-2:0], miso};
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] got;
      logic [AW+DW:0] ab;
      for (int i = 0; i < 16; i++) begin
         imem[i] = 8'h10 + 8'(i);
         dmem[i] = 8'hA0 + 8'(i);
      end
      dmem[7] = 8'h5A;

      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      idle(1, 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset mem_wdata", mem_wdata, 0);
      chk("reset mem_sel", mem_sel, 0);
      chk("reset err_code", err_code, 0);
      chk("reset busy", busy, 0);
      chk("reset miso", miso, 0);

      // icache write, commit in the first cycle after the frame
      send_write(0, 4'h3, 8'hB5, 0);
      idle(1, 0);
      chk("wr commit count", commits.size(), 1);
      chk("wr commit word", commits.size() > 0 ? commits[0] : '1, {1'b0, 4'h3, 8'hB5});
      idle(1, 0);
      chk("wr hold addr", mem_addr, 4'h3);
      chk("wr hold wdata", mem_wdata, 8'hB5);
      chk("wr busy after", busy, 0);

      // dcache and icache readback
      send_read(1, 4'h7, 0, got);
      chk("rd dcache byte", got, 8'h5A);
      chk("rd err", err_code, 0);
      idle(1, 0);
      send_read(0, 4'h2, 0, got);
      chk("rd icache byte", got, 8'h12);
      idle(1, 0);

      // write held while the core runs
      send_write(1, 4'h2, 8'h0F, 1);
      idle(3, 1);
      chk("stall no commit", commits.size(), 1);
      chk("stall busy", busy, 1);
      idle(2, 0);
      chk("stall commit count", commits.size(), 2);
      chk("stall commit word", commits.size() > 1 ? commits[1] : '1, {1'b1, 4'h2, 8'h0F});
      chk("stall busy cleared", busy, 0);

      // overrun: second write lost
      send_write(1, 4'h5, 8'h11, 1);
      idle(1, 1);
      send_write(0, 4'h6, 8'h22, 1);
      idle(1, 1);
      chk("ovr err", err_code, 2);
      idle(4, 0);
      chk("ovr commit count", commits.size(), 3);
      chk("ovr commit word", commits.size() > 2 ? commits[2] : '1, {1'b1, 4'h5, 8'h11});

      // read while core busy returns zeros
      step(0, 1, 1, 0, 0, 1);
      idle(1, 0);
      chk("clr err", err_code, 0);
      send_read(0, 4'h4, 1, got);
      chk("rd busy byte", got, 8'h00);
      chk("rd busy err", err_code, 2);
      step(0, 1, 1, 0, 0, 1);

      // abort after six bits on dcache
      ab = {1'b1, 4'h9, 8'h00};
      for (int i = AW + DW; i > AW + DW - 6; i--) step(0, 1, 0, ab[i], 0, 0);
      step(0, 1, 1, 0, 0, 0);
      idle(1, 0);
      chk("abort err", err_code, 1);
      chk("abort no commit", commits.size(), 3);
      chk("abort busy", busy, 0);

      // bad select, with err_clr in the same cycle, then blocked until both high
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0);
      idle(1, 0);
      chk("badsel err", err_code, 3);
      chk("badsel busy", busy, 0);

      // reset with a pending write and a frame in flight
      send_write(0, 4'h9, 8'h77, 1);
      idle(1, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1, 0);
      step(1, 1, 1, 0, 1, 0);
      idle(1, 1);
      chk("rst busy", busy, 0);
      chk("rst err", err_code, 0);
      idle(3, 0);
      chk("rst dropped pending", commits.size(), 3);
      send_write(0, 4'h1, 8'hC3, 0);
      idle(2, 0);
      chk("post rst commit count", commits.size(), 4);
      chk("post rst commit word", commits.size() > 3 ? commits[3] : '1, {1'b0, 4'h1, 8'hC3});
      chk("post rst err", err_code, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
